// File: rtl/digit_serial_subtractor_32_bit_pkg.sv
// Shared definitions for the adder/subtractor family: FSM state encoding and default sizes.
package adders_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned DIGIT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/digit_serial_subtractor_32_bit_if.sv
// Operand/result handshake bundle for the digit-serial subtractor.
interface digit_serial_subtractor_32_bit_if
  import adders_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
);

  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_minuend;
  logic [WIDTH-1:0] i_subtrahend;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_result;
  logic             o_borrow;
  logic             o_OF;

  // Requester side: supplies operands and consumes results.
  modport master (
    output i_valid, i_minuend, i_subtrahend, i_ready,
    input  o_ready, o_valid, o_result, o_borrow, o_OF
  );

  // Subtractor side.
  modport slave (
    input  i_valid, i_minuend, i_subtrahend, i_ready,
    output o_ready, o_valid, o_result, o_borrow, o_OF
  );

endinterface

// File: rtl/digit_serial_subtractor_32_bit_full_subtractor.sv
// One-bit full subtractor: diff = a - b - bin, with borrow out.
module full_subtractor (
  input  logic i_bit1,
  input  logic i_bit2,
  input  logic i_borrow,
  output logic o_diff,
  output logic o_borrow
);

  assign o_diff   = i_bit1 ^ i_bit2 ^ i_borrow;
  assign o_borrow = (~i_bit1 & i_bit2) | (~(i_bit1 ^ i_bit2) & i_borrow);

endmodule

// File: rtl/digit_serial_subtractor_32_bit.sv
// Multi-cycle subtractor: A - B computed DIGIT bits per clock through a registered borrow,
// with borrow-out and signed overflow, valid/ready on both sides.
module digit_serial_subtractor_32_bit
  import adders_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DIGIT = DIGIT_DEF
) (
  input logic                          i_clk,
  input logic                          i_rst_n,
  digit_serial_subtractor_32_bit_if.slave bus
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = $clog2(NDIG + 1);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("WIDTH must be a multiple of DIGIT");
  end

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             borrow_q;
  logic [CW-1:0]    cnt_q;
  logic             a_sign_q;
  logic             b_sign_q;
  logic             ready_q;
  logic             valid_q;
  logic [WIDTH-1:0] result_q;
  logic             borrow_out_q;
  logic             of_q;

  // Digit datapath: DIGIT full subtractors rippling from the stored borrow.
  logic [DIGIT:0]   chain;
  logic [DIGIT-1:0] diff;

  assign chain[0] = borrow_q;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fs
    full_subtractor u_fs (
      .i_bit1   (a_q[i]),
      .i_bit2   (b_q[i]),
      .i_borrow (chain[i]),
      .o_diff   (diff[i]),
      .o_borrow (chain[i+1])
    );
  end

  // Each new digit enters at the MSB end, so after NDIG steps digit 0 sits at the LSB.
  logic [WIDTH-1:0] res_next;
  logic             last_digit;
  logic             of_next;

  assign res_next   = (res_q >> DIGIT) | (WIDTH'(diff) << (WIDTH - DIGIT));
  assign last_digit = (cnt_q == CW'(NDIG - 1));
  assign of_next    = (a_sign_q ^ b_sign_q) & (res_next[WIDTH-1] ^ a_sign_q);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      borrow_q     <= 1'b0;
      cnt_q        <= '0;
      a_sign_q     <= 1'b0;
      b_sign_q     <= 1'b0;
      ready_q      <= 1'b1;
      valid_q      <= 1'b0;
      result_q     <= '0;
      borrow_out_q <= 1'b0;
      of_q         <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.i_valid && ready_q) begin
            a_q      <= bus.i_minuend;
            b_q      <= bus.i_subtrahend;
            a_sign_q <= bus.i_minuend[WIDTH-1];
            b_sign_q <= bus.i_subtrahend[WIDTH-1];
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            state_q  <= ST_BUSY;
          end
        end

        ST_BUSY: begin
          a_q      <= a_q >> DIGIT;
          b_q      <= b_q >> DIGIT;
          res_q    <= res_next;
          borrow_q <= chain[DIGIT];
          cnt_q    <= cnt_q + CW'(1);
          // Visible result fields move only here, so a partial result never shows.
          if (last_digit) begin
            result_q     <= res_next;
            borrow_out_q <= chain[DIGIT];
            of_q         <= of_next;
            valid_q      <= 1'b1;
            state_q      <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (bus.i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end

        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_ready  = ready_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_result = result_q;
  assign bus.o_borrow = borrow_out_q;
  assign bus.o_OF     = of_q;

endmodule

// File: tb/tb_digit_serial_subtractor_32_bit.sv
// Directed bench for the digit-serial subtractor: protocol/arithmetic model plus literal vectors.
module tb_digit_serial_subtractor_32_bit;

  localparam int unsigned W    = 32;
  localparam int unsigned NDIG = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;

  digit_serial_subtractor_32_bit_if #(.WIDTH(W)) bus ();

  digit_serial_subtractor_32_bit #(.WIDTH(W), .DIGIT(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: result is plain modular arithmetic, revealed NDIG edges after acceptance.
  logic          m_ready = 1'b1;
  logic          m_valid = 1'b0;
  logic [W-1:0]  m_res   = '0;
  logic          m_bor   = 1'b0;
  logic          m_of    = 1'b0;
  logic [W-1:0]  m_a     = '0;
  logic [W-1:0]  m_b     = '0;
  int            m_left  = 0;

  function automatic logic signed_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sd;
    sd = longint'($signed(a)) - longint'($signed(b));
    return (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready <= 1'b1; m_valid <= 1'b0; m_res <= '0; m_bor <= 1'b0; m_of <= 1'b0; m_left <= 0;
    end else if (m_ready && bus.i_valid) begin
      m_ready <= 1'b0;
      m_a     <= bus.i_minuend;
      m_b     <= bus.i_subtrahend;
      m_left  <= NDIG;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_valid <= 1'b1;
        m_res   <= m_a - m_b;
        m_bor   <= (m_a < m_b);
        m_of    <= signed_ovf(m_a, m_b);
      end
    end else if (m_valid && bus.i_ready) begin
      m_valid <= 1'b0;
      m_ready <= 1'b1;
    end
  end

  // Every cycle out of reset, all outputs must match the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("o_ready",  64'(bus.o_ready),  64'(m_ready));
      chk("o_valid",  64'(bus.o_valid),  64'(m_valid));
      chk("o_result", 64'(bus.o_result), 64'(m_res));
      chk("o_borrow", 64'(bus.o_borrow), 64'(m_bor));
      chk("o_OF",     64'(bus.o_OF),     64'(m_of));
    end
  end

  // Present operands, wait for the result, check latency and literal expectations.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    chk("ready_before_accept", 64'(bus.o_ready), 64'd1);
    bus.i_valid      = 1'b1;
    bus.i_minuend    = a;
    bus.i_subtrahend = b;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input logic [W-1:0] er, input logic eb, input logic eo);
    int lat;
    lat = 0;
    while (lat < 20 && !bus.o_valid) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.o_valid) begin
      chk({name, "_timeout"}, 64'd0, 64'd1);
    end else begin
      chk({name, "_latency"}, 64'(lat), 64'(NDIG));
      chk({name, "_result"},  64'(bus.o_result), 64'(er));
      chk({name, "_borrow"},  64'(bus.o_borrow), 64'(eb));
      chk({name, "_of"},      64'(bus.o_OF),     64'(eo));
    end
  endtask

  task automatic finish_handshake(input string name);
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    chk({name, "_valid_drop"}, 64'(bus.o_valid), 64'd0);
    chk({name, "_idle_ready"}, 64'(bus.o_ready), 64'd1);
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er, input logic eb, input logic eo);
    start_op(a, b);
    wait_result(name, er, eb, eo);
    finish_handshake(name);
  endtask

  initial begin
    logic [W-1:0] held;
    bus.i_valid      = 1'b0;
    bus.i_ready      = 1'b1;
    bus.i_minuend    = '0;
    bus.i_subtrahend = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_ready",  64'(bus.o_ready),  64'd1);
    chk("reset_valid",  64'(bus.o_valid),  64'd0);
    chk("reset_result", 64'(bus.o_result), 64'd0);

    run_op("t1_5m3",   32'd5,          32'd3,          32'h0000_0002, 1'b0, 1'b0);
    run_op("t2_0m1",   32'd0,          32'd1,          32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("t3_minm1", 32'h8000_0000,  32'h0000_0001,  32'h7FFF_FFFF, 1'b0, 1'b1);
    run_op("t4_maxmn", 32'h7FFF_FFFF,  32'hFFFF_FFFF,  32'h8000_0000, 1'b1, 1'b1);
    run_op("eq",       32'hDEAD_BEEF,  32'hDEAD_BEEF,  32'h0000_0000, 1'b0, 1'b0);
    run_op("mixed",    32'h1234_5678,  32'h0FED_CBA9,  32'h0246_8ACF, 1'b0, 1'b0);

    // Backpressure: result held while new operands are offered and ignored.
    bus.i_ready = 1'b0;
    start_op(32'h0000_0010, 32'h0000_0001);
    wait_result("t5_first", 32'h0000_000F, 1'b0, 1'b0);
    bus.i_valid      = 1'b1;
    bus.i_minuend    = 32'h0000_0100;
    bus.i_subtrahend = 32'h0000_0001;
    held = bus.o_result;
    repeat (5) begin
      @(posedge clk); #1;
      chk("t5_hold_ready",  64'(bus.o_ready),  64'd0);
      chk("t5_hold_valid",  64'(bus.o_valid),  64'd1);
      chk("t5_hold_result", 64'(bus.o_result), 64'(held));
    end
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    chk("t5_back_idle", 64'(bus.o_ready), 64'd1);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    chk("t5_accepted", 64'(bus.o_ready), 64'd0);
    wait_result("t5_second", 32'h0000_00FF, 1'b0, 1'b0);
    finish_handshake("t5_second");

    // Reset mid-operation aborts with no result flagged.
    start_op(32'hFFFF_0000, 32'h0000_FFFF);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ready",  64'(bus.o_ready),  64'd1);
    chk("t6_rst_valid",  64'(bus.o_valid),  64'd0);
    chk("t6_rst_result", 64'(bus.o_result), 64'd0);
    chk("t6_rst_borrow", 64'(bus.o_borrow), 64'd0);
    chk("t6_rst_of",     64'(bus.o_OF),     64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("t6_post_valid", 64'(bus.o_valid), 64'd0);
    run_op("t6_after", 32'h1234_5678, 32'h0234_5678, 32'h1000_0000, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
